// File: rtl/mac_dot_accum_if.sv
// Operand-tag input and finished-sum output bundle of mac_dot_accum.
// The design side uses the slave modport; the producer/consumer uses master.
interface mac_dot_accum_if #(
  parameter int BITS = 8,
  parameter int LEN  = 4,
  parameter int ACCW = 2*BITS+8
);
  localparam int TW = $clog2(LEN+1);

  logic              in_valid;
  logic              in_last;
  logic [2*BITS-1:0] mac_o;
  logic              out_valid;
  logic              out_ready;
  logic [ACCW-1:0]   out_data;
  logic [TW-1:0]     out_terms;

  modport master (
    output in_valid, in_last, mac_o, out_ready,
    input  out_valid, out_data, out_terms
  );

  modport slave (
    input  in_valid, in_last, mac_o, out_ready,
    output out_valid, out_data, out_terms
  );
endinterface

// File: rtl/mac_dot_accum.sv
// Sums tagged runs of upstream MAC results into dot products and queues
// each finished sum with its term count behind a valid/ready FIFO.
module mac_dot_accum #(
  parameter int BITS  = 8,
  parameter int LAT   = 4,
  parameter int LEN   = 4,
  parameter int ACCW  = 2*BITS+8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  mac_dot_accum_if.slave bus,
  input  logic           clear,
  output logic           busy,
  output logic           drop
);
  localparam int TW = $clog2(LEN+1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {EMPTY, RUN} state_t;

  state_t          state, state_nxt;
  logic [LAT-1:0]  tag_v, tag_l;
  logic            tag_hit, tag_last;
  logic [ACCW-1:0] acc, acc_nxt, sum;
  logic [TW-1:0]   terms, terms_nxt, cnt;
  logic            close;

  logic [ACCW-1:0] mem_data  [DEPTH];
  logic [TW-1:0]   mem_terms [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            fifo_empty, fifo_full, pop, push_ok;

  // Tag line mirrors the upstream latency so the oldest stage lines up with mac_o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v <= '0;
      tag_l <= '0;
    end else if (clear) begin
      tag_v <= '0;
      tag_l <= '0;
    end else begin
      tag_v[0] <= bus.in_valid;
      tag_l[0] <= bus.in_valid & bus.in_last;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
    end
  end

  assign tag_hit  = tag_v[LAT-1];
  assign tag_last = tag_l[LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      acc   <= '0;
      terms <= '0;
    end else if (clear) begin
      state <= EMPTY;
      acc   <= '0;
      terms <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      terms <= terms_nxt;
    end
  end

  // An EMPTY accumulator starts from zero, so a single-term close still pushes mac_o.
  always_comb begin
    sum       = ((state == RUN) ? acc : '0) + ACCW'(bus.mac_o);
    cnt       = ((state == RUN) ? terms : '0) + TW'(1);
    close     = tag_hit && (tag_last || (cnt == TW'(LEN)));
    state_nxt = state;
    acc_nxt   = acc;
    terms_nxt = terms;
    if (tag_hit) begin
      acc_nxt   = sum;
      terms_nxt = cnt;
      state_nxt = close ? EMPTY : RUN;
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && bus.out_ready;
  assign push_ok    = close && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (close && !push_ok) begin
        drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem_data[wr_ptr[AW-1:0]]  <= sum;
      mem_terms[wr_ptr[AW-1:0]] <= cnt;
    end
  end

  // Storage is not reset, so the head is forced to zero whenever the FIFO is empty.
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign bus.out_terms = fifo_empty ? '0 : mem_terms[rd_ptr[AW-1:0]];
  assign busy          = (|tag_v) || (state == RUN);
endmodule

// File: doc/mac_dot_accum.md
# mac_dot_accum

Result-side companion to the 4-stage multiply-add pipeline. It sits directly downstream of that pipeline and consumes its 2*BITS result stream. A valid/last tag travels alongside each issued operand set with matching latency, so the block knows which results are real. It sums runs of results into dot products and queues the finished sums in a small FIFO behind a valid/ready output handshake.

## Interface
- BITS, 8, operand width of upstream MAC; result input is 2*BITS wide
- LAT, 4, upstream pipeline latency in cycles (tag delay depth), ≥1
- LEN, 4, maximum terms per dot product; a dot product closes at LEN terms even without in_last, ≥1
- ACCW, 2*BITS+8, accumulator/output width
- DEPTH, 4, output FIFO entries, power of two, ≥2

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  high in the same cycle operands are presented to the upstream MAC
- in_last  in  1  qualifies in_valid; marks final term of a dot product
- mac_o  in  2*BITS  upstream MAC result, unsigned
- clear  in  1  synchronous flush: tags, accumulator, term count, FIFO, drop
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- out_data  out  ACCW  FIFO head sum
- out_terms  out  $clog2(LEN+1)  number of terms in head sum
- busy  out  1  any tag in flight or accumulator non-empty
- drop  out  1  sticky: a finished sum was discarded because FIFO was full

## Operation
- Tag line: LAT-deep shift register of {valid,last}, loaded from {in_valid, in_valid&in_last} every cycle; in_last without in_valid ignored. The tag leaving stage LAT qualifies mac_o in that cycle.
- Accumulator states: EMPTY, RUN.
  - EMPTY + valid tag: acc=zext(mac_o), terms=1; go to RUN, unless the close condition holds.
  - RUN + valid tag: acc+=zext(mac_o), terms+=1.
  - Close condition: tag.last, or terms reaches LEN including the current term.
  - On close, push {acc+mac_o, terms} in the same cycle; go to EMPTY.
  - No valid tag: hold.
- Arithmetic: unsigned, modulo 2^ACCW; carry out discarded silently.
- FIFO push when full:
  - If out_ready&out_valid in the same cycle, pop and push both happen.
  - Otherwise the sum is discarded, drop is set, and the accumulator still returns to EMPTY.
- drop clears only on rst or clear.
- FIFO order strictly preserved; out_data/out_terms stable while out_valid & !out_ready.
- clear has priority over all same-cycle events. A tag arriving in the clear cycle is discarded.

## Timing
- Reset values: out_valid=0, out_data=0, out_terms=0, busy=0, drop=0; tag line all zero; state EMPTY; FIFO empty.
- rst asserted mid-operation: everything reset immediately; in-flight tags lost; no partial sum emitted after release.
- in_valid sampled at edge t → matching mac_o sampled at edge t+LAT.
- Push of a closing term at edge t+LAT → out_valid high after that edge. Total issue-to-out_valid latency is LAT+1 edges.
- Back-to-back dot products with no gap are supported; a new term may arrive the cycle after a close.
- Outputs registered; no combinational path from out_ready to out_valid/out_data. Full throughput is one pop per cycle.
- busy is combinational OR of tag valids and state==RUN.

## Test plan
- Basic (defaults): in_valid at edges 0–3, in_last at 3, mac_o=10,20,30,40 at edges 4–7 → out_valid after edge 7, out_data=100, out_terms=4.
- Early last plus LEN cap, LEN=4: terms 5 (last), then 1,1,1,1,1 with no last → sums 5 (terms 1), 4 (terms 4), then 1 remains in RUN with busy=1.
- Gaps: in_valid at edges 0,2,5 (last at 5); mac_o garbage (0xFFFF) in non-tag cycles → out_data equals the sum of the three tagged values only.
- Wrap: ACCW=16, two terms of 0xFFFF → out_data=0xFFFE, drop=0.
- Backpressure: out_ready=0, 5 single-term dot products (last every term), DEPTH=4 → 4 entries queued in order, 5th discarded, drop=1. Then out_ready=1 pops all 4 in order, one per cycle.
- Full plus simultaneous pop: FIFO full, out_ready=1 in the push cycle → push accepted, drop stays 0.
- Reset/clear mid-run: assert rst (low) with 2 tags in flight and acc in RUN → all outputs 0 immediately, no output after release. Repeat with clear → same result one edge later.
